// File: rtl/fp_postprocess_pkg.sv
// Shared constants for the floating-point multiplier back end.
package fp_postprocess_pkg;

  localparam int WIDTH    = 32;
  localparam int WEXP     = 8;
  localparam int WSIG     = 23;
  localparam int BIAS     = 127;
  localparam int WCONTROL = 2;

  typedef enum logic [WCONTROL-1:0] {
    RM_RN = 2'b00,
    RM_RZ = 2'b01,
    RM_RP = 2'b10,
    RM_RM = 2'b11
  } round_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_HOLD
  } state_t;

  localparam logic [WIDTH-1:0] QNAN = {1'b0, {WEXP{1'b1}}, 1'b1, {(WSIG-1){1'b0}}};

endpackage

// File: rtl/fp_round_inc.sv
// Decides whether the truncated significand is incremented for the selected rounding mode.
module fp_round_inc
  import fp_postprocess_pkg::*;
(
  input  logic [WCONTROL-1:0] roundmode,
  input  logic                sign,
  input  logic                lsb,
  input  logic                guard,
  input  logic                sticky,
  output logic                inc
);

  always_comb begin
    inc = 1'b0;
    case (round_mode_t'(roundmode))
      RM_RN:   inc = guard & (sticky | lsb);
      RM_RZ:   inc = 1'b0;
      RM_RP:   inc = (guard | sticky) & ~sign;
      RM_RM:   inc = (guard | sticky) & sign;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_postprocess.sv
// Floating-point multiplier back end: normalizes, denormalizes and rounds the
// significand product, then packs the IEEE result with exception flags.
module fp_postprocess #(
  parameter int WIDTH = fp_postprocess_pkg::WIDTH,
  parameter int WEXP  = fp_postprocess_pkg::WEXP,
  parameter int WSIG  = fp_postprocess_pkg::WSIG,
  parameter int BIAS  = fp_postprocess_pkg::BIAS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*WSIG+1:0]      prod,
  input  logic signed [WEXP+1:0] exp_sum,
  input  logic                   sign,
  input  logic                   zero,
  input  logic                   aisnan,
  input  logic                   bisnan,
  input  logic                   infinity,
  input  logic [1:0]             roundmode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact,
  output logic                   invalid
);
  import fp_postprocess_pkg::*;

  localparam int P  = 2*WSIG+2;
  localparam int WE = WEXP+2;
  localparam logic signed [WE:0]   EXP_MAX = (WE+1)'(2*BIAS+1);
  localparam logic signed [WE-1:0] EXP_ONE = WE'(1);
  localparam logic signed [WE-1:0] EXP_TOP = {1'b0, {(WE-1){1'b1}}};
  localparam logic [WIDTH-1:0]     QNAN_W  = {1'b0, {WEXP{1'b1}}, 1'b1, {(WSIG-1){1'b0}}};

  state_t               state_q, state_d;
  logic [P-1:0]         sig_q, sig_d;
  logic                 sticky_q, sticky_d;
  logic signed [WE-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d;
  round_mode_t          rmode_q, rmode_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d, inv_q, inv_d;

  logic [WSIG-1:0]      frac;
  logic                 hidden, guard, rsticky, inc, to_inf;
  logic [WSIG+1:0]      rsum;
  logic signed [WE:0]   exp_rnd;
  logic [WIDTH-1:0]     rnd_result;
  logic                 rnd_ovf, rnd_unf, rnd_inx;

  assign hidden  = sig_q[2*WSIG];
  assign frac    = sig_q[2*WSIG-1:WSIG];
  assign guard   = sig_q[WSIG-1];
  assign rsticky = sticky_q | (|sig_q[WSIG-2:0]);

  fp_round_inc u_round_inc (
    .roundmode (rmode_q),
    .sign      (sign_q),
    .lsb       (frac[0]),
    .guard     (guard),
    .sticky    (rsticky),
    .inc       (inc)
  );

  // A carry out of {hidden,frac} leaves an all-zero fraction one binade up.
  assign rsum    = {1'b0, hidden, frac} + {{(WSIG+1){1'b0}}, inc};
  assign exp_rnd = {exp_q[WE-1], exp_q} + {{WE{1'b0}}, rsum[WSIG+1]};
  assign to_inf  = (rmode_q == RM_RN) | ((rmode_q == RM_RP) & ~sign_q) |
                   ((rmode_q == RM_RM) & sign_q);

  always_comb begin
    rnd_inx = guard | rsticky;
    rnd_unf = ~hidden & rnd_inx;
    rnd_ovf = 1'b0;
    if (rsum[WSIG+1])
      rnd_result = {sign_q, exp_rnd[WEXP-1:0], {WSIG{1'b0}}};
    else if (rsum[WSIG])
      rnd_result = {sign_q, exp_rnd[WEXP-1:0], rsum[WSIG-1:0]};
    else
      rnd_result = {sign_q, {WEXP{1'b0}}, rsum[WSIG-1:0]};
    if (exp_rnd >= EXP_MAX) begin
      rnd_ovf = 1'b1;
      rnd_inx = 1'b1;
      rnd_unf = 1'b0;
      if (to_inf)
        rnd_result = {sign_q, {WEXP{1'b1}}, {WSIG{1'b0}}};
      else
        rnd_result = {sign_q, {(WEXP-1){1'b1}}, 1'b0, {WSIG{1'b1}}};
    end
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    sticky_d = sticky_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    rmode_d  = rmode_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    inv_d    = inv_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sig_d    = prod;
          sticky_d = 1'b0;
          exp_d    = exp_sum;
          sign_d   = sign;
          rmode_d  = round_mode_t'(roundmode);
          result_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inx_d    = 1'b0;
          inv_d    = 1'b0;
          state_d  = S_NORM;
          // Special operands bypass the datapath and are packed on the accept edge.
          if (aisnan | bisnan | (infinity & zero)) begin
            result_d = QNAN_W;
            inv_d    = infinity & zero;
            state_d  = S_HOLD;
          end else if (infinity) begin
            result_d = {sign, {WEXP{1'b1}}, {WSIG{1'b0}}};
            state_d  = S_HOLD;
          end else if (zero) begin
            result_d = {sign, {(WIDTH-1){1'b0}}};
            state_d  = S_HOLD;
          end
        end
      end
      S_NORM: begin
        if (sig_q[P-1] || (exp_q < EXP_ONE)) begin
          sig_d    = sig_q >> 1;
          sticky_d = sticky_q | sig_q[0];
          exp_d    = (exp_q == EXP_TOP) ? exp_q : exp_q + EXP_ONE;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        result_d = rnd_result;
        ovf_d    = rnd_ovf;
        unf_d    = rnd_unf;
        inx_d    = rnd_inx;
        inv_d    = 1'b0;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sig_q    <= '0;
      sticky_q <= 1'b0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      rmode_q  <= RM_RN;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      sticky_q <= sticky_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      rmode_q  <= rmode_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
      inv_q    <= inv_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;
  assign invalid   = inv_q;

endmodule
